// File: rtl/mux_scan_ctrl.sv
// Scanned reader for a 4:1 mux tree: steps {s1,s0} through channels 0..3, samples y
// after SETTLE cycles per channel and hands the 4-bit word out over valid/ack.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 1,
    parameter bit          AUTO   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    input  logic       ack,
    output logic       s1,
    output logic       s0,
    output logic [3:0] result,
    output logic       valid,
    output logic       busy
);

    generate
        if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
            $fatal(1, "mux_scan_ctrl: SETTLE must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] shadow_q, shadow_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] result_q, result_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;

    // Next-state logic; the select register always leads with the channel about to be sampled.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        sel_d    = sel_q;
        result_d = result_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        case (state_q)
            ST_IDLE: begin
                sel_d = 2'b00;
                if (start) begin
                    state_d = ST_SCAN;
                    ch_d    = 2'd0;
                    cnt_d   = RELOAD;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (ch_q != 2'd3) begin
                    shadow_d[ch_q] = y;
                    ch_d           = ch_q + 2'd1;
                    sel_d          = ch_q + 2'd1;
                    cnt_d          = RELOAD;
                end else begin
                    result_d = {y, shadow_q};
                    valid_d  = 1'b1;
                    sel_d    = 2'b00;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ack) begin
                    valid_d = 1'b0;
                    // Auto mode chains straight into the next scan; channel 0 is already driven.
                    if (AUTO) begin
                        state_d = ST_SCAN;
                        ch_d    = 2'd0;
                        cnt_d   = RELOAD;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ch_d     = 2'd0;
                cnt_d    = 4'd0;
                shadow_d = 3'b000;
                sel_d    = 2'b00;
                valid_d  = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ch_q     <= 2'd0;
            cnt_q    <= 4'd0;
            shadow_q <= 3'b000;
            sel_q    <= 2'b00;
            result_q <= 4'b0000;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign s1     = sel_q[1];
    assign s0     = sel_q[0];
    assign result = result_q;
    assign valid  = valid_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances (SETTLE/AUTO = 1/0, 3/0, 2/1) each reading a
// modelled 4:1 mux whose lanes the bench sets, checked against the scan timing rules.
module tb_mux_scan_ctrl;

    localparam int SET_P [3] = '{1, 3, 2};
    localparam bit AUTO_P[3] = '{1'b0, 1'b0, 1'b1};

    logic       clk;
    logic       rst_n;
    logic       start_r [3];
    logic       ack_r   [3];
    logic [3:0] lane_r  [3];
    logic       y_w     [3];
    logic       s1_w    [3];
    logic       s0_w    [3];
    logic [3:0] result_w[3];
    logic       valid_w [3];
    logic       busy_w  [3];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign y_w[g] = lane_r[g][{s1_w[g], s0_w[g]}];
        mux_scan_ctrl #(.SETTLE(SET_P[g]), .AUTO(AUTO_P[g])) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start_r[g]),
            .y     (y_w[g]),
            .ack   (ack_r[g]),
            .s1    (s1_w[g]),
            .s0    (s0_w[g]),
            .result(result_w[g]),
            .valid (valid_w[g]),
            .busy  (busy_w[g])
        );
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if ({s1_w[k], s0_w[k], result_w[k], valid_w[k], busy_w[k]} !== 8'b0) begin
                    n_fail++;
                    $display("FAIL reset_idle inst=%0d cyc=%0d got sel=%b%b res=%b v=%b b=%b exp all zero",
                             k, c, s1_w[k], s0_w[k], result_w[k], valid_w[k], busy_w[k]);
                end
            end
        end
    endtask

    // One full scan: start pulse, select sequence, latency, final result.
    task automatic run_scan(input int k, input logic [3:0] lanes, input bit poke);
        logic [1:0] exp_sel;
        int s;
        s = SET_P[k];
        lane_r[k] = lanes;
        @(posedge clk); #1 start_r[k] = 1'b1;
        @(posedge clk); #1 start_r[k] = 1'b0;
        for (int j = 0; j < 4 * s; j++) begin
            @(negedge clk);
            exp_sel = 2'(j / s);
            n_checks++;
            if ({s1_w[k], s0_w[k]} !== exp_sel) begin
                n_fail++;
                $display("FAIL scan_sel inst=%0d j=%0d got %b%b exp %b", k, j, s1_w[k], s0_w[k], exp_sel);
            end
            n_checks++;
            if (valid_w[k] !== 1'b0 || busy_w[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL scan_flags inst=%0d j=%0d got v=%b b=%b exp v=0 b=1", k, j, valid_w[k], busy_w[k]);
            end
            if (poke) start_r[k] = (j == 2);
        end
        start_r[k] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (valid_w[k] !== 1'b1 || busy_w[k] !== 1'b1 || {s1_w[k], s0_w[k]} !== 2'b00) begin
            n_fail++;
            $display("FAIL scan_done inst=%0d got v=%b b=%b sel=%b%b exp v=1 b=1 sel=00",
                     k, valid_w[k], busy_w[k], s1_w[k], s0_w[k]);
        end
        n_checks++;
        if (result_w[k] !== lanes) begin
            n_fail++;
            $display("FAIL scan_result inst=%0d got %b exp %b", k, result_w[k], lanes);
        end
    endtask

    // Ack issued from a negedge while valid; valid must fall on the very next edge.
    task automatic do_ack(input int k, input logic [3:0] lanes);
        ack_r[k] = 1'b1;
        @(posedge clk); #1 ack_r[k] = 1'b0;
        n_checks++;
        if (valid_w[k] !== 1'b0 || busy_w[k] !== AUTO_P[k] || result_w[k] !== lanes) begin
            n_fail++;
            $display("FAIL ack_edge inst=%0d got v=%b b=%b res=%b exp v=0 b=%b res=%b",
                     k, valid_w[k], busy_w[k], result_w[k], AUTO_P[k], lanes);
        end
    endtask

    task automatic test_basic_scan();
        logic [3:0] l;
        run_scan(0, 4'b1010, 1'b0);
        do_ack(0, 4'b1010);
        for (int i = 0; i < 5; i++) begin
            l = 4'($urandom);
            run_scan(0, l, 1'b0);
            do_ack(0, l);
        end
    endtask

    task automatic test_settle_stall();
        run_scan(1, 4'b0101, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (valid_w[1] !== 1'b1 || busy_w[1] !== 1'b1 || result_w[1] !== 4'b0101) begin
                n_fail++;
                $display("FAIL stall_hold cyc=%0d got v=%b b=%b res=%b exp v=1 b=1 res=0101",
                         c, valid_w[1], busy_w[1], result_w[1]);
            end
        end
        do_ack(1, 4'b0101);
    endtask

    task automatic test_ignored_controls();
        logic [3:0] l;
        l = 4'($urandom);
        run_scan(1, l, 1'b1);
        start_r[1] = 1'b1;
        do_ack(1, l);
        start_r[1] = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            ack_r[1] = (c == 3);
            n_checks++;
            if (valid_w[1] !== 1'b0 || busy_w[1] !== 1'b0 || {s1_w[1], s0_w[1]} !== 2'b00
                || result_w[1] !== l) begin
                n_fail++;
                $display("FAIL ignored_idle cyc=%0d got v=%b b=%b sel=%b%b res=%b exp v=0 b=0 sel=00 res=%b",
                         c, valid_w[1], busy_w[1], s1_w[1], s0_w[1], result_w[1], l);
            end
        end
        ack_r[1] = 1'b0;
    endtask

    task automatic test_auto_mode();
        logic [3:0] l;
        bit         exp_v;
        l = 4'($urandom);
        lane_r[2] = l;
        ack_r[2]  = 1'b1;
        @(posedge clk); #1 start_r[2] = 1'b1;
        @(posedge clk); #1 start_r[2] = 1'b0;
        for (int c = 1; c <= 46; c++) begin
            @(negedge clk);
            exp_v = (c % 9 == 0);
            n_checks++;
            if (valid_w[2] !== exp_v || busy_w[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL auto_timing cyc=%0d got v=%b b=%b exp v=%b b=1", c, valid_w[2], busy_w[2], exp_v);
            end
            if (exp_v) begin
                n_checks++;
                if (result_w[2] !== l) begin
                    n_fail++;
                    $display("FAIL auto_result cyc=%0d got %b exp %b", c, result_w[2], l);
                end
                l = 4'($urandom);
                lane_r[2] = l;
            end
        end
        ack_r[2] = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        logic [3:0] l;
        bit         found;
        l = 4'($urandom);
        lane_r[1] = l;
        found = 1'b0;
        @(posedge clk); #1 start_r[1] = 1'b1;
        @(posedge clk); #1 start_r[1] = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if ({s1_w[1], s0_w[1]} == 2'b10) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL reset_mid_wait got no sel=10 within 20 cycles exp sel=10");
        end
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({s1_w[k], s0_w[k], result_w[k], valid_w[k], busy_w[k]} !== 8'b0) begin
                n_fail++;
                $display("FAIL reset_mid_async inst=%0d got sel=%b%b res=%b v=%b b=%b exp all zero",
                         k, s1_w[k], s0_w[k], result_w[k], valid_w[k], busy_w[k]);
            end
        end
        @(posedge clk); #1 rst_n = 1'b1;
        l = 4'($urandom);
        run_scan(1, l, 1'b0);
        do_ack(1, l);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            start_r[k] = 1'b0;
            ack_r[k]   = 1'b0;
            lane_r[k]  = 4'b0000;
        end
        rst_n = 1'b0;
        test_reset();
        test_basic_scan();
        test_settle_stall();
        test_ignored_controls();
        test_auto_mode();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer that sits directly upstream of the 4:1 mux tree. It drives the shared select pair {s1,s0} through channels 0..3 and samples the tree's single-bit output `y` after a programmable settle time per channel. It assembles the four samples into a 4-bit word and hands that word to the consumer over a valid/ack handshake. This turns one combinational mux path into a scanned, registered channel reader.

## Interface
- `SETTLE`, default 1: cycles each select value is held before `y` is sampled. Legal range is 1..15; 0 is illegal, and elaboration must fail on it.
- `AUTO`, default 0: when 1, an accepted ack immediately starts the next scan without a new `start`.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to `clk` by the system.
- `start`  in  1  one-cycle request to begin a scan. Sampled only in IDLE.
- `y`  in  1  output of the 4:1 mux tree, combinational function of {s1,s0}.
- `ack`  in  1  consumer accepts `result`. Sampled only while `valid`=1.
- `s1`  out  1  select MSB to the mux tree. Registered.
- `s0`  out  1  select LSB to the mux tree. Registered.
- `result`  out  4  `result[i]` is `y` sampled while {s1,s0}=i. Registered.
- `valid`  out  1  `result` holds a complete scan.
- `busy`  out  1  high from scan start until ack is accepted.

## Operation
- Reset values: s1=0, s0=0, result=4'b0000, valid=0, busy=0. State=IDLE, ch=0, cnt=0, shadow=3'b000.
- States:
  - IDLE: {s1,s0}=00.
  - SCAN: ch 0..3, down-counter cnt.
  - HOLD: result presented.
- IDLE, start=1: go to SCAN with ch=0, cnt=SETTLE-1, busy=1. When start=0, stay in IDLE.
- SCAN:
  - {s1,s0}=ch.
  - cnt>0: decrement cnt.
  - cnt==0 and ch<3: shadow[ch]<=y, ch<=ch+1, cnt<=SETTLE-1.
  - cnt==0 and ch==3: result<={y,shadow[2:0]}, valid<=1, {s1,s0}<=00, go to HOLD.
- HOLD: result and valid hold stable and busy=1 until ack=1.
  - ack=1, AUTO=0: valid<=0, busy<=0, go to IDLE.
  - ack=1, AUTO=1: valid<=0, busy stays 1, go to SCAN with ch=0, cnt=SETTLE-1.
- Ignored inputs: start outside IDLE, including start coincident with ack in HOLD, is dropped and not queued. ack outside HOLD has no effect.
- result keeps its last value after ack until the next scan completes. It changes only on a completing sample.
- Counters: ch is 2 bits, cnt is 4 bits, and neither ever wraps. ch increments only from 0..2; cnt reloads before it could underflow.
- Reset mid-scan or mid-HOLD: all outputs return to reset values asynchronously. Any partial scan is discarded.

## Timing
- start seen at edge E.
  - Channel i is sampled at edge E+(i+1)·SETTLE.
  - valid rises after edge E+4·SETTLE.
  - Latency from start to valid is 4·SETTLE cycles. With SETTLE=1, valid is high 4 cycles after start.
- {s1,s0} changes on the edge after a sample. Channel i is driven for exactly SETTLE cycles before its sample edge; channel 0 is already driven in IDLE.
- Handshake: transfer occurs at the edge where valid=1 and ack=1.
  - valid falls on that same edge.
  - With AUTO=1, the next scan's channel-0 sample is SETTLE cycles after the ack edge.
- Minimum scan period with AUTO=0 and ack tied high: 4·SETTLE+2 cycles, made up of scan, HOLD, and IDLE with start.

## Test plan
- Reset and idle: rst_n low, then high; no start. Required: s1=s0=0, result=0000, valid=0, busy=0 held for 20 cycles.
- Basic scan:
  - Setup: SETTLE=1; mux lanes driven so y=1 for ch1 and ch3 (y=1 when s0=1); one-cycle start.
  - Sequence: {s1,s0} goes 00,01,10,11 on consecutive cycles.
  - Result: valid high 4 cycles after start; result=4'b1010; busy=1 throughout.
- Settle and stall:
  - Setup: SETTLE=3, y=0101 pattern (y=1 when s0=0); ack held low 10 cycles.
  - Required: each select held exactly 3 cycles; result=4'b0101 stable with valid=1 for all 10 cycles; valid falls on the ack edge.
- Ignored controls: start pulsed mid-scan and in HOLD together with ack; ack pulsed in IDLE. Required: no restart, no extra scan, state returns to IDLE after the real ack.
- AUTO mode:
  - Setup: AUTO=1, SETTLE=2, ack tied high.
  - Required: back-to-back scans; valid high one cycle every 9 cycles; busy never drops after the first start.
- Reset mid-scan: rst_n asserted while {s1,s0}=10. Required: outputs immediately at reset values; after release, a new start yields a correct full scan.
